// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache and its way storage.
package cache_pkg;

  // Widest tag any configuration may use; way metadata carries tags zero-extended to this.
  localparam int MAX_TAG_W = 64;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WRITEBACK   = 3'd1,
    REFILL_REQ  = 3'd2,
    REFILL_WAIT = 3'd3,
    RESPOND     = 3'd4
  } cache_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [MAX_TAG_W-1:0] tag;
  } way_meta_t;

  function automatic int index_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int addr_width, input int num_sets);
    return addr_width - $clog2(num_sets) - 2;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid/dirty/tag/data, combinational read,
// byte-strobed hit write and whole-line install.
module cache_way
  import cache_pkg::*;
#(
  parameter int NUM_SETS   = 256,
  parameter int TAG_W      = 22,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(NUM_SETS),
  localparam int NB        = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      index,
  output way_meta_t             rd_meta,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [NB-1:0]         wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  inst_en,
  input  logic [TAG_W-1:0]      inst_tag,
  input  logic                  inst_dirty,
  input  logic [DATA_WIDTH-1:0] inst_data
);

  logic [NUM_SETS-1:0]   valid_q;
  logic [NUM_SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_q [NUM_SETS];

  // Only the status bits are reset; tags and data are meaningless while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inst_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= inst_dirty;
    end else if (wr_en && |wr_be) begin
      dirty_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (inst_en) begin
      tag_q[index]  <= inst_tag;
      data_q[index] <= inst_data;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) data_q[index][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_meta = '{valid: valid_q[index], dirty: dirty_q[index],
                     tag: MAX_TAG_W'(tag_q[index])};
  assign rd_data = data_q[index];

endmodule

// File: rtl/setassoc_cache.sv
// N-way set-associative write-back/write-allocate cache with a single-beat
// memory port; hit/victim selection, round-robin replacement and miss FSM.
module setassoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 256,
  parameter int NUM_WAYS   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH/8-1:0] req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata
);

  localparam int IDX_W = index_width(NUM_SETS);
  localparam int TAG_W = tag_width(ADDR_WIDTH, NUM_SETS);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the requester holds valid and payload stable until then.
  cache_state_e state, state_d;

  logic [NB-1:0]         lat_we;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [IDX_W-1:0]      lat_index;
  logic [TAG_W-1:0]      lat_tag;
  logic [WAY_W-1:0]      lat_way;
  logic [WAY_W-1:0]      rr_q [NUM_SETS];

  logic [IDX_W-1:0]      req_index, cur_index;
  logic [TAG_W-1:0]      req_tag;
  logic                  accept;
  way_meta_t             way_meta [NUM_WAYS];
  logic [DATA_WIDTH-1:0] way_data [NUM_WAYS];
  logic [NUM_WAYS-1:0]   way_wr_en, way_inst_en;

  logic                  hit, has_invalid, victim_dirty;
  logic [WAY_W-1:0]      hit_way, inv_way, victim_way, rr_cur, rr_next;
  way_meta_t             victim_meta;
  logic [DATA_WIDTH-1:0] victim_data, hit_merged, refill_merged;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  unused_bits;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] base,
                                                       input logic [DATA_WIDTH-1:0] wdata,
                                                       input logic [NB-1:0] be);
    logic [DATA_WIDTH-1:0] res;
    res = base;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  assign req_index   = req_addr[IDX_W+1:2];
  assign req_tag     = req_addr[ADDR_WIDTH-1:IDX_W+2];
  assign unused_bits = &{1'b0, req_addr[1:0]};
  // Lookups in IDLE use the live request; miss handling uses the latched one.
  assign cur_index   = (state == IDLE) ? req_index : lat_index;
  assign accept      = req_valid && req_ready;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    cache_way #(
      .NUM_SETS  (NUM_SETS),
      .TAG_W     (TAG_W),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .index     (cur_index),
      .rd_meta   (way_meta[g]),
      .rd_data   (way_data[g]),
      .wr_en     (way_wr_en[g]),
      .wr_be     (req_we),
      .wr_data   (req_wdata),
      .inst_en   (way_inst_en[g]),
      .inst_tag  (lat_tag),
      .inst_dirty(|lat_we),
      .inst_data (refill_merged)
    );
  end

  // Hit detection and victim choice: lowest-index match / lowest-index invalid way.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    inv_way     = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_meta[w].valid && (way_meta[w].tag == MAX_TAG_W'(req_tag))) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!way_meta[w].valid) begin
        has_invalid = 1'b1;
        inv_way     = WAY_W'(w);
      end
    end
  end

  assign rr_cur        = rr_q[req_index];
  assign rr_next       = (NUM_WAYS == 1) ? '0 : WAY_W'(rr_cur + WAY_W'(1));
  assign victim_way    = has_invalid ? inv_way : rr_cur;
  assign victim_meta   = way_meta[victim_way];
  assign victim_data   = way_data[victim_way];
  assign victim_dirty  = victim_meta.valid && victim_meta.dirty;
  assign wb_addr       = ADDR_WIDTH'(victim_meta.tag << (IDX_W + 2))
                       | ADDR_WIDTH'({req_index, 2'b00});
  assign hit_merged    = merge_bytes(way_data[hit_way], req_wdata, req_we);
  assign refill_merged = merge_bytes(mem_resp_rdata, lat_wdata, lat_we);

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_wr_en[w]   = accept && hit && (hit_way == WAY_W'(w));
      way_inst_en[w] = (state == REFILL_WAIT) && mem_resp_valid && (lat_way == WAY_W'(w));
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (hit)               state_d = RESPOND;
          else if (victim_dirty) state_d = WRITEBACK;
          else                   state_d = REFILL_REQ;
        end
      end
      WRITEBACK:   if (mem_req_ready)  state_d = REFILL_REQ;
      REFILL_REQ:  if (mem_req_ready)  state_d = REFILL_WAIT;
      REFILL_WAIT: if (mem_resp_valid) state_d = RESPOND;
      RESPOND:                         state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESPOND);
  assign mem_req_valid = (state == WRITEBACK) || (state == REFILL_REQ);
  assign mem_req_we    = (state == WRITEBACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we        <= '0;
      lat_wdata     <= '0;
      lat_index     <= '0;
      lat_tag       <= '0;
      lat_way       <= '0;
      resp_rdata    <= '0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_wdata <= req_wdata;
            lat_index <= req_index;
            lat_tag   <= req_tag;
            lat_way   <= hit ? hit_way : victim_way;
            if (hit) begin
              resp_rdata <= hit_merged;
            end else begin
              if (!has_invalid) rr_q[req_index] <= rr_next;
              if (victim_dirty) begin
                mem_req_addr  <= wb_addr;
                mem_req_wdata <= victim_data;
              end else begin
                mem_req_addr <= {req_tag, req_index, 2'b00};
              end
            end
          end
        end
        WRITEBACK: if (mem_req_ready) mem_req_addr <= {lat_tag, lat_index, 2'b00};
        REFILL_WAIT: if (mem_resp_valid) resp_rdata <= refill_merged;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_setassoc_cache.sv
// Directed bench for setassoc_cache: scoreboarded responses and memory traffic
// against a data=address memory model with programmable stall and response delay.
module tb_setassoc_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int total = 0;
  int bad   = 0;
  int resp_delay = 0;

  logic [31:0] exp_q[$];
  logic [64:0] exp_mem_q[$];
  logic [31:0] mem_q [logic [31:0]];
  logic [64:0] mem_obs;
  logic [31:0] rnd_w, rnd_exp;
  logic [3:0]  rnd_be;

  setassoc_cache dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] base, input logic [31:0] wd,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_q.exists(a) ? mem_q[a] : a;
  endfunction

  // Memory model: accepts at the edge after a negedge sample of valid && ready.
  initial begin : mem_model
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid && mem_req_ready) begin
        mem_obs = {mem_req_we, mem_req_addr, mem_req_we ? mem_req_wdata : 32'h0};
        chk("mem_expected", 65'(exp_mem_q.size() > 0), 65'(1'b1));
        if (exp_mem_q.size() > 0) chk("mem_req", mem_obs, exp_mem_q.pop_front());
        @(posedge clk);
        if (mem_obs[64]) begin
          mem_q[mem_obs[63:32]] = mem_obs[31:0];
        end else begin
          repeat (resp_delay) @(posedge clk);
          #1;
          mem_resp_valid = 1'b1;
          mem_resp_rdata = mem_read(mem_obs[63:32]);
          @(posedge clk);
          #1;
          mem_resp_valid = 1'b0;
        end
      end
    end
  end

  // Driver tasks
  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_mem_q.push_back({we, addr, wdata});
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", 65'(req_ready), 65'(1'b1));
    chk("rst_resp_valid", 65'(resp_valid), 65'(1'b0));
    chk("rst_mem_req_valid", 65'(mem_req_valid), 65'(1'b0));
    chk("rst_mem_req_we", 65'(mem_req_we), 65'(1'b0));
    chk("rst_resp_rdata", 65'(resp_rdata), 65'(0));
    chk("rst_mem_req_addr", 65'(mem_req_addr), 65'(0));
    chk("rst_mem_req_wdata", 65'(mem_req_wdata), 65'(0));
  endtask

  // Called #1 after a rising edge with the cache idle; returns #1 after the accepting edge.
  task automatic start_req(input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data);
    exp_q.push_back(exp_data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    chk("req_ready", 65'(req_ready), 65'(1'b1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = '0;
  endtask

  task automatic wait_resp(input int exp_lat);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 300 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk("resp_seen", 65'(got), 65'(1'b1));
    if (got) begin
      chk("resp_rdata", 65'(resp_rdata), 65'(exp_q.pop_front()));
      chk("resp_latency", 65'(lat), 65'(exp_lat));
    end
    @(posedge clk);
    #1;
    chk("resp_pulse", 65'(resp_valid), 65'(1'b0));
    chk("mem_drained", 65'(exp_mem_q.size()), 65'(0));
  endtask

  initial begin : stimulus
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_we        = '0;
    req_addr      = '0;
    req_wdata     = '0;
    mem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();

    // Cold read, then hit
    push_mem(1'b0, 32'h10, 32'h0);
    start_req(4'h0, 32'h10, 32'h0, 32'h0000_0010);
    wait_resp(3);
    start_req(4'h0, 32'h10, 32'h0, 32'h0000_0010);
    wait_resp(1);

    // Partial write hit and readback
    start_req(4'b0011, 32'h10, 32'hDEAD_BEEF, 32'h0000_BEEF);
    wait_resp(1);
    start_req(4'h0, 32'h10, 32'h0, 32'h0000_BEEF);
    wait_resp(1);

    // Write-allocate miss, then a random strobed write hit and readback
    push_mem(1'b0, 32'h20, 32'h0);
    start_req(4'b1100, 32'h20, 32'h5A5A_5A5A, 32'h5A5A_0020);
    wait_resp(3);
    rnd_w   = $urandom;
    rnd_be  = 4'($urandom_range(1, 15));
    rnd_exp = byte_merge(32'h5A5A_0020, rnd_w, rnd_be);
    start_req(rnd_be, 32'h20, rnd_w, rnd_exp);
    wait_resp(1);
    start_req(4'h0, 32'h20, 32'h0, rnd_exp);
    wait_resp(1);

    // Fill way 1 of set 4, then evict the dirty way 0
    push_mem(1'b0, 32'h410, 32'h0);
    start_req(4'h0, 32'h410, 32'h0, 32'h0000_0410);
    wait_resp(3);
    push_mem(1'b1, 32'h10, 32'h0000_BEEF);
    push_mem(1'b0, 32'h810, 32'h0);
    start_req(4'h0, 32'h810, 32'h0, 32'h0000_0810);
    wait_resp(4);

    // Refill request held off for 5 cycles
    mem_req_ready = 1'b0;
    push_mem(1'b0, 32'hC10, 32'h0);
    start_req(4'h0, 32'hC10, 32'h0, 32'h0000_0C10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_mem_req_valid", 65'(mem_req_valid), 65'(1'b1));
      chk("stall_mem_req_addr", 65'(mem_req_addr), 65'(32'hC10));
      chk("stall_req_ready", 65'(req_ready), 65'(1'b0));
    end
    @(posedge clk);
    #1;
    mem_req_ready = 1'b1;
    wait_resp(3);

    // 0x10 comes back from memory with the written-back data
    push_mem(1'b0, 32'h10, 32'h0);
    start_req(4'h0, 32'h10, 32'h0, 32'h0000_BEEF);
    wait_resp(3);
    start_req(4'h0, 32'h10, 32'h0, 32'h0000_BEEF);
    wait_resp(1);

    // Reset while waiting for refill data; the late response must be ignored
    resp_delay = 3;
    push_mem(1'b0, 32'h1010, 32'h0);
    start_req(4'h0, 32'h1010, 32'h0, 32'h0000_1010);
    @(posedge clk);
    #1;
    chk("wait_busy", 65'(req_ready), 65'(1'b0));
    rst_n = 1'b0;
    #1;
    chk("rst_async_ready", 65'(req_ready), 65'(1'b1));
    chk("rst_async_mem_req_valid", 65'(mem_req_valid), 65'(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_outputs();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_resp_after_rst", 65'(resp_valid), 65'(1'b0));
    end
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("abort_mem_drained", 65'(exp_mem_q.size()), 65'(0));
    resp_delay = 0;

    push_mem(1'b0, 32'h10, 32'h0);
    start_req(4'h0, 32'h10, 32'h0, 32'h0000_BEEF);
    wait_resp(3);

    // Reset while a refill request is stalled drops mem_req_valid at once
    mem_req_ready = 1'b0;
    start_req(4'h0, 32'h2010, 32'h0, 32'h0000_2010);
    @(negedge clk);
    chk("stall2_mem_req_valid", 65'(mem_req_valid), 65'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    mem_req_ready = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("final_mem_drained", 65'(exp_mem_q.size()), 65'(0));
    chk("final_idle", 65'(req_ready), 65'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
